// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Each instruction takes 3-5 cycles, plus one cycle per memory wait.
// Memory states hold, with their request asserted, until mem_ready. Outputs decode combinationally from state, and from mem_ready where a state needs it.
module mips_multicycle_control #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Op,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               AluSrcA,
  output logic [1:0]         AluSrcB,
  output logic [1:0]         AluOp,
  output logic [1:0]         PCSource,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXECUTE   = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EX   = 4'd11,
    ADDI_WB   = 4'd12
  } state_t;

  state_t state;
  logic   memRdy;
  logic   opLegal;

  // With waits disabled, every memory access completes in its first cycle.
  assign memRdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  assign opLegal = (Op == OP_RTYPE) || (Op == OP_J) || (Op == OP_BEQ) ||
                   (Op == OP_ADDI) || (Op == OP_LW) || (Op == OP_SW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:     state <= FETCH;
        FETCH:    if (memRdy) state <= DECODE;
        DECODE: begin
          case (Op)
            OP_LW, OP_SW: state <= MEM_ADDR;
            OP_RTYPE:     state <= EXECUTE;
            OP_BEQ:       state <= BRANCH;
            OP_J:         state <= JUMP;
            OP_ADDI:      state <= ADDI_EX;
            default:      state <= FETCH;
          endcase
        end
        MEM_ADDR:  state <= (Op == OP_SW) ? MEM_WRITE : MEM_READ;
        MEM_READ:  if (memRdy) state <= MEM_WB;
        MEM_WB:    state <= FETCH;
        MEM_WRITE: if (memRdy) state <= FETCH;
        EXECUTE:   state <= R_WB;
        R_WB:      state <= FETCH;
        BRANCH:    state <= FETCH;
        JUMP:      state <= FETCH;
        ADDI_EX:   state <= ADDI_WB;
        ADDI_WB:   state <= FETCH;
        default:   state <= FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    AluOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (state)
      FETCH: begin
        // PC+4 is computed every cycle, but PC and IR load only on the completing cycle.
        MemRead = 1'b1;
        AluSrcB = 2'b01;
        IRWrite = memRdy;
        PCWrite = memRdy;
      end
      DECODE: begin
        AluSrcB    = 2'b11;
        illegal_op = !opLegal;
      end
      MEM_ADDR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = memRdy;
      end
      EXECUTE: begin
        AluSrcA = 1'b1;
        AluOp   = 2'b10;
      end
      R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        AluSrcA     = 1'b1;
        AluOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      ADDI_EX: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
      end
      ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_dbg = STATE_W'(state);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control. It builds a per-instruction cycle trace from opcode and wait counts.
// It then compares the DUT cycle by cycle, covering directed cases, a mid-instruction reset and random instruction streams.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, AluSrcA;
  logic [1:0] AluSrcB, AluOp, PCSource;
  logic       instr_done, illegal_op;
  logic [3:0] state_dbg;

  int total = 0;
  int bad   = 0;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSource(PCSource),
    .instr_done(instr_done), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Observed control word, MSB first: PCWrite .. illegal_op
  logic [17:0] obsO;
  assign obsO = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, PCSource, instr_done, illegal_op};

  localparam logic [17:0] O_PCW   = 18'h20000;
  localparam logic [17:0] O_PCWC  = 18'h10000;
  localparam logic [17:0] O_IORD  = 18'h08000;
  localparam logic [17:0] O_MR    = 18'h04000;
  localparam logic [17:0] O_MW    = 18'h02000;
  localparam logic [17:0] O_IRW   = 18'h01000;
  localparam logic [17:0] O_M2R   = 18'h00800;
  localparam logic [17:0] O_RD    = 18'h00400;
  localparam logic [17:0] O_RW    = 18'h00200;
  localparam logic [17:0] O_ASA   = 18'h00100;
  localparam logic [17:0] O_B4    = 18'h00040;
  localparam logic [17:0] O_BIMM  = 18'h00080;
  localparam logic [17:0] O_BSH   = 18'h000C0;
  localparam logic [17:0] O_SUB   = 18'h00010;
  localparam logic [17:0] O_FN    = 18'h00020;
  localparam logic [17:0] O_PCOUT = 18'h00004;
  localparam logic [17:0] O_PCJ   = 18'h00008;
  localparam logic [17:0] O_DONE  = 18'h00002;
  localparam logic [17:0] O_ILL   = 18'h00001;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  typedef struct packed {
    logic [3:0]  st;
    logic        rdy;
    logic [17:0] o;
  } step_t;

  function automatic bit isLegal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, JMP, ADDI};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doStep(input step_t e, input string tag, output logic done);
    mem_ready = e.rdy;
    @(negedge clk);
    check({tag, "/state"}, 32'(state_dbg), 32'(e.st));
    check({tag, "/outputs"}, 32'(obsO), 32'(e.o));
    check({tag, "/rd_wr_excl"}, 32'(MemRead & MemWrite), 32'd0);
    check({tag, "/done_ill_excl"}, 32'(instr_done & illegal_op), 32'd0);
    done = instr_done;
    @(posedge clk);
    #1;
  endtask

  // Expected trace of one instruction from its first FETCH cycle to retirement.
  task automatic runInstr(input logic [5:0] op, input int fw, input int mw, input string tag);
    step_t q[$];
    step_t s;
    int    base, waits, doneAt;
    logic  d;
    Op = op;
    for (int i = 0; i < fw; i++) begin
      s = '{4'd1, 1'b0, O_MR | O_B4};
      q.push_back(s);
    end
    s = '{4'd1, 1'b1, O_MR | O_B4 | O_IRW | O_PCW};
    q.push_back(s);
    s = '{4'd2, 1'($urandom), O_BSH | (isLegal(op) ? 18'h0 : O_ILL)};
    q.push_back(s);
    waits = 0;
    base  = -1;
    case (op)
      LW: begin
        base = 5; waits = mw;
        s = '{4'd3, 1'($urandom), O_ASA | O_BIMM}; q.push_back(s);
        for (int i = 0; i < mw; i++) begin
          s = '{4'd4, 1'b0, O_MR | O_IORD}; q.push_back(s);
        end
        s = '{4'd4, 1'b1, O_MR | O_IORD}; q.push_back(s);
        s = '{4'd5, 1'($urandom), O_RW | O_M2R | O_DONE}; q.push_back(s);
      end
      SW: begin
        base = 4; waits = mw;
        s = '{4'd3, 1'($urandom), O_ASA | O_BIMM}; q.push_back(s);
        for (int i = 0; i < mw; i++) begin
          s = '{4'd6, 1'b0, O_MW | O_IORD}; q.push_back(s);
        end
        s = '{4'd6, 1'b1, O_MW | O_IORD | O_DONE}; q.push_back(s);
      end
      RT: begin
        base = 4;
        s = '{4'd7, 1'($urandom), O_ASA | O_FN}; q.push_back(s);
        s = '{4'd8, 1'($urandom), O_RW | O_RD | O_DONE}; q.push_back(s);
      end
      BEQ: begin
        base = 3;
        s = '{4'd9, 1'($urandom), O_ASA | O_SUB | O_PCWC | O_PCOUT | O_DONE}; q.push_back(s);
      end
      JMP: begin
        base = 3;
        s = '{4'd10, 1'($urandom), O_PCW | O_PCJ | O_DONE}; q.push_back(s);
      end
      ADDI: begin
        base = 4;
        s = '{4'd11, 1'($urandom), O_ASA | O_BIMM}; q.push_back(s);
        s = '{4'd12, 1'($urandom), O_RW | O_DONE}; q.push_back(s);
      end
      default: base = -1;
    endcase
    doneAt = -1;
    foreach (q[i]) begin
      doStep(q[i], tag, d);
      if (d === 1'b1 && doneAt < 0) doneAt = i + 1;
    end
    // Illegal opcodes never retire; legal ones retire after base + waits cycles.
    check({tag, "/cycles"}, 32'(doneAt), (base < 0) ? 32'hFFFF_FFFF : 32'(base + fw + waits));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step_t s;
    logic  d;
    logic [5:0] opTab [6];
    logic [5:0] rop;
    opTab = '{LW, SW, RT, BEQ, JMP, ADDI};
    rst_n = 1'b0;
    Op = 6'd0;
    mem_ready = 1'b0;
    #12;
    check("reset/state", 32'(state_dbg), 32'd0);
    check("reset/outputs", 32'(obsO), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle/state", 32'(state_dbg), 32'd0);
    check("idle/outputs", 32'(obsO), 32'd0);
    @(posedge clk);
    #1;

    runInstr(RT, 0, 0, "rtype");
    runInstr(LW, 2, 2, "lw_wait");
    runInstr(SW, 0, 0, "sw");
    runInstr(BEQ, 0, 0, "beq");
    runInstr(JMP, 0, 0, "j");
    runInstr(6'b111111, 0, 0, "illegal");
    runInstr(ADDI, 1, 0, "addi");
    runInstr(SW, 0, 3, "sw_wait");

    // Reset asserted while MEM_READ waits for memory
    Op = LW;
    s = '{4'd1, 1'b1, O_MR | O_B4 | O_IRW | O_PCW}; doStep(s, "rst_mid", d);
    s = '{4'd2, 1'b1, O_BSH};                       doStep(s, "rst_mid", d);
    s = '{4'd3, 1'b1, O_ASA | O_BIMM};              doStep(s, "rst_mid", d);
    s = '{4'd4, 1'b0, O_MR | O_IORD};               doStep(s, "rst_mid", d);
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid/async_state", 32'(state_dbg), 32'd0);
    check("rst_mid/async_memread", 32'(MemRead), 32'd0);
    check("rst_mid/async_outputs", 32'(obsO), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid/idle", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #1;
    runInstr(LW, 0, 1, "after_rst");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        do rop = 6'($urandom); while (isLegal(rop));
      end else begin
        rop = opTab[$urandom_range(0, 5)];
      end
      runInstr(rop, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rand%0d_op%b", n, rop));
    end
    runInstr(RT, 0, 0, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
